// File: rtl/layer_params_deserializer.sv
// layer_params_deserializer
//
// Collects TOTAL_PARAMS sequential parameter words into one layer-parameter
// record and queues completed records in a small circular buffer for the
// layer-control logic. Words arrive highest field first, so the first word
// lands in field TOTAL_PARAMS-1 and the last word is field 0 (`valid`).
// A completed record whose `valid` bit (bit 0 of the final word) is clear is
// dropped and raises a sticky format error.
//
// Ports:
//   clk            single clock
//   reset          asynchronous active-high reset
//   flush          synchronous clear, same effect as reset
//   in_data        parameter word
//   in_valid       in_data is valid
//   in_ready       word accepted on in_valid && in_ready
//   out_params     head record, field k at [k*PARAM_WIDTH +: PARAM_WIDTH]
//   out_valid      buffer holds at least one record
//   out_ready      head popped on out_valid && out_ready
//   new_layer_edge one-cycle pulse in the cycle after each pop
//   word_idx       index of the next expected word
//   format_err     sticky: a record arrived with its valid bit clear
module layer_params_deserializer #(
  parameter int TOTAL_PARAMS = 34,
  parameter int PARAM_WIDTH  = 28,
  parameter int DEPTH        = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [PARAM_WIDTH-1:0]               in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [TOTAL_PARAMS*PARAM_WIDTH-1:0]  out_params,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 new_layer_edge,
  output logic [$clog2(TOTAL_PARAMS)-1:0]      word_idx,
  output logic                                 format_err
);

  localparam int IDX_W = $clog2(TOTAL_PARAMS);
  localparam int REC_W = TOTAL_PARAMS * PARAM_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_PARAMS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [REC_W-1:0] asm_q, asm_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             format_err_q, format_err_d;
  logic             new_layer_edge_q, new_layer_edge_d;

  logic [REC_W-1:0] buf_mem [DEPTH];

  logic last_word;
  logic accept;
  logic push;
  logic pop;
  int   slot;

  assign last_word = (word_idx_q == LAST_IDX);
  // The final word stalls only while the buffer is full; a pop in the same
  // cycle does not open the gate, keeping in_ready a pure register decode.
  assign in_ready  = !(last_word && (count_q == FULL_CNT));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign slot      = TOTAL_PARAMS - 1 - int'(word_idx_q);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    word_idx_d       = word_idx_q;
    asm_d            = asm_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    format_err_d     = format_err_q;
    new_layer_edge_d = pop;
    push             = 1'b0;

    if (accept) begin
      for (int k = 0; k < TOTAL_PARAMS; k++) begin
        if (k == slot) asm_d[k*PARAM_WIDTH +: PARAM_WIDTH] = in_data;
      end
      if (last_word) begin
        word_idx_d = '0;
        if (in_data[0]) push = 1'b1;
        else            format_err_d = 1'b1;
      end else begin
        word_idx_d = word_idx_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Soft reset wins over everything, including a same-cycle push or pop.
    if (flush) begin
      word_idx_d       = '0;
      asm_d            = '0;
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      count_d          = '0;
      format_err_d     = 1'b0;
      new_layer_edge_d = 1'b0;
      push             = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx_q       <= '0;
      asm_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      format_err_q     <= 1'b0;
      new_layer_edge_q <= 1'b0;
    end else begin
      word_idx_q       <= word_idx_d;
      asm_q            <= asm_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      format_err_q     <= format_err_d;
      new_layer_edge_q <= new_layer_edge_d;
    end
  end

  // NOTE: the record storage is not reset; slots are only ever read while the
  // occupancy count says they hold a pushed record, and out_params is forced
  // to zero when the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_q] <= asm_d;
  end

  assign out_params     = out_valid ? buf_mem[rd_ptr_q] : '0;
  assign new_layer_edge = new_layer_edge_q;
  assign word_idx       = word_idx_q;
  assign format_err     = format_err_q;

endmodule

// File: tb/tb_layer_params_deserializer.sv
// Directed and randomized checks for layer_params_deserializer.
module tb_layer_params_deserializer;

  localparam int TP    = 34;
  localparam int PW    = 28;
  localparam int DEPTH = 2;
  localparam int REC_W = TP * PW;
  localparam int IDX_W = $clog2(TP);
  localparam int NREC  = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [PW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [REC_W-1:0]  out_params;
  logic              out_valid;
  logic              out_ready;
  logic              new_layer_edge;
  logic [IDX_W-1:0]  word_idx;
  logic              format_err;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  layer_params_deserializer #(
    .TOTAL_PARAMS(TP), .PARAM_WIDTH(PW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_params(out_params), .out_valid(out_valid), .out_ready(out_ready),
    .new_layer_edge(new_layer_edge), .word_idx(word_idx),
    .format_err(format_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (new_layer_edge === 1'b1) edge_cnt++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic [REC_W-1:0] exp);
    for (int k = 0; k < TP; k++)
      check($sformatf("%s.f%0d", tag, k),
            64'(out_params[k*PW +: PW]), 64'(exp[k*PW +: PW]));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".in_ready"},   64'(in_ready), 64'd1);
    check({tag, ".out_valid"},  64'(out_valid), 64'd0);
    check({tag, ".out_params"}, 64'(|out_params), 64'd0);
    check({tag, ".edge"},       64'(new_layer_edge), 64'd0);
    check({tag, ".word_idx"},   64'(word_idx), 64'd0);
    check({tag, ".format_err"}, 64'(format_err), 64'd0);
  endtask

  // Presents one word and returns at +1 after the edge that accepted it.
  task automatic send_word(input logic [PW-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 2000) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_words(input logic [REC_W-1:0] rec, input int n);
    for (int i = 0; i < n; i++) send_word(rec[(TP-1-i)*PW +: PW]);
  endtask

  function automatic logic [REC_W-1:0] idx_rec(input int base, input logic [PW-1:0] f0);
    logic [REC_W-1:0] r;
    for (int k = 1; k < TP; k++) r[k*PW +: PW] = PW'(base + k);
    r[PW-1:0] = f0;
    return r;
  endfunction

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    for (int k = 0; k < TP; k++) r[k*PW +: PW] = PW'($urandom);
    r[0] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  logic [REC_W-1:0] r1, r2, r3;
  logic [REC_W-1:0] sb [$];
  int pops;
  int edge0;

  initial begin
    // ---------------- reset state
    do_reset();
    chk_idle("reset");

    // ---------------- single record
    r1 = idx_rec(32'h100, 28'h1);
    out_ready = 1'b1;
    send_words(r1, TP);
    check("single.out_valid", 64'(out_valid), 64'd1);
    check("single.f33", 64'(out_params[33*PW +: PW]), 64'h121);
    chk_rec("single", r1);
    check("single.word_idx", 64'(word_idx), 64'd0);
    step();
    check("single.edge", 64'(new_layer_edge), 64'd1);
    check("single.empty", 64'(out_valid), 64'd0);
    step();
    check("single.edge_low", 64'(new_layer_edge), 64'd0);
    out_ready = 1'b0;

    // ---------------- backpressure
    do_reset();
    r1 = idx_rec(32'h200, 28'h3);
    r2 = idx_rec(32'h300, 28'h5);
    r3 = idx_rec(32'h400, 28'h7);
    send_words(r1, TP);
    send_words(r2, TP);
    check("bp.ready_full_idx0", 64'(in_ready), 64'd1);
    send_words(r3, TP - 1);
    check("bp.word_idx", 64'(word_idx), 64'd33);
    check("bp.stall", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = r3[PW-1:0];
    step();
    step();
    check("bp.stall_hold", 64'(in_ready), 64'd0);
    check("bp.idx_hold", 64'(word_idx), 64'd33);
    chk_rec("bp.head1", r1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp.release", 64'(in_ready), 64'd1);
    check("bp.edge", 64'(new_layer_edge), 64'd1);
    chk_rec("bp.head2", r2);
    step();
    in_valid = 1'b0;
    check("bp.accept_idx", 64'(word_idx), 64'd0);
    check("bp.edge_low", 64'(new_layer_edge), 64'd0);
    out_ready = 1'b1;
    step();
    chk_rec("bp.head3", r3);
    step();
    out_ready = 1'b0;
    check("bp.drained", 64'(out_valid), 64'd0);

    // ---------------- bad record
    do_reset();
    r1 = idx_rec(32'h500, 28'h0);
    send_words(r1, TP);
    check("bad.format_err", 64'(format_err), 64'd1);
    check("bad.word_idx", 64'(word_idx), 64'd0);
    check("bad.no_push", 64'(out_valid), 64'd0);
    r2 = idx_rec(32'h600, 28'h9);
    send_words(r2, TP);
    check("bad.next_valid", 64'(out_valid), 64'd1);
    chk_rec("bad.next", r2);
    check("bad.sticky", 64'(format_err), 64'd1);

    // ---------------- mid-record asynchronous reset
    do_reset();
    r1 = idx_rec(32'h700, 28'hB);
    send_words(r1, TP);               // one record buffered
    send_words(r1, 10);
    #3 reset = 1'b1;
    #1;
    chk_idle("async_rst");
    step();
    reset = 1'b0;
    step();
    r2 = idx_rec(32'h800, 28'hD);
    send_words(r2, TP);
    check("async_rst.valid", 64'(out_valid), 64'd1);
    chk_rec("async_rst.rec", r2);

    // ---------------- simultaneous push and pop
    do_reset();
    r1 = idx_rec(32'h900, 28'h11);
    r2 = idx_rec(32'hA00, 28'h13);
    send_words(r1, TP);
    send_words(r2, TP - 1);
    out_ready = 1'b1;
    send_word(r2[PW-1:0]);
    out_ready = 1'b0;
    check("pp.valid", 64'(out_valid), 64'd1);
    check("pp.edge", 64'(new_layer_edge), 64'd1);
    chk_rec("pp.head", r2);
    step();
    check("pp.edge_once", 64'(new_layer_edge), 64'd0);
    check("pp.occupancy1", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp.empty", 64'(out_valid), 64'd0);

    // ---------------- flush mid-record with same-cycle pop and word
    do_reset();
    r1 = idx_rec(32'hB00, 28'h15);
    send_words(r1, TP);
    send_words(r1, 5);
    step();
    check("flush.pre_err", 64'(format_err), 64'd0);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 28'h123;
    step();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk_idle("flush");

    // ---------------- random traffic against a scoreboard
    do_reset();
    pops  = 0;
    edge0 = edge_cnt;
    fork
      begin
        for (int r = 0; r < NREC; r++) begin
          logic [REC_W-1:0] rr;
          rr = rand_rec();
          sb.push_back(rr);
          for (int i = 0; i < TP; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send_word(rr[(TP-1-i)*PW +: PW]);
          end
        end
      end
      begin
        int cyc = 0;
        while (pops < NREC && cyc < 40000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (sb.size() > 0) chk_rec($sformatf("rand%0d", pops), sb.pop_front());
            pops++;
          end
          step();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    step();
    step();
    check("rand.pops", 64'(pops), 64'(NREC));
    check("rand.edges", 64'(edge_cnt - edge0), 64'(pops));
    check("rand.empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
